memw_init_ctrl: RTL and testbench

MEMW_INIT_CTRL -- requirements
Module: memw_init_ctrl

---
 rtl/memw_init_ctrl.sv | 120 ++++++++++++
 tb/tb_memw_init_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/memw_init_ctrl.sv
// Byte-enabled single-port RAM that self-initialises with a fixed pattern after reset
// or on request, and only serves user reads/writes once the fill has completed.
module memw_init_ctrl #(
  parameter int              DATA_W     = 32,
  parameter int              ADDR_W     = 16,
  parameter int              DEPTH_LOG2 = 14,
  parameter int              INIT_MODE  = 0,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   data,
  input  logic                wren,
  input  logic [DATA_W/8-1:0] byteena,
  input  logic                init_req,
  output logic [DATA_W-1:0]   q,
  output logic                rdy
);

  localparam int NB    = DATA_W / 8;
  localparam int BOFF  = $clog2(NB);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [DEPTH_LOG2-1:0]   cnt_reg, cnt_next;
  logic                    rdy_reg, rdy_next;
  logic                    fill_we, user_we, in_ready;
  logic [DEPTH_LOG2-1:0]   user_word, wr_word;
  logic [DATA_W-1:0]       fill_data, wr_data;
  logic [NB-1:0]           lane_we;
  logic                    addr_unused;

  // Offset bits and bits above the word index are aliases of the same word.
  assign user_word   = address[BOFF +: DEPTH_LOG2];
  assign addr_unused = ^address;
  assign in_ready    = (state_reg == READY);

  always_comb begin
    fill_data = '0;
    if (INIT_MODE == 1)
      fill_data = INIT_VALUE;
    else if (INIT_MODE == 2)
      fill_data = DATA_W'(cnt_reg);
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    fill_we    = 1'b0;
    user_we    = 1'b0;
    case (state_reg)
      HOLD: begin
        state_next = FILL;
        cnt_next   = '0;
      end
      FILL: begin
        fill_we  = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (&cnt_reg)
          state_next = READY;
      end
      READY: begin
        if (init_req) begin
          state_next = FILL;
          cnt_next   = '0;
        end else begin
          user_we = wren;
        end
      end
      default: state_next = HOLD;
    endcase
    // Drops on the init_req edge itself, rises one edge after the fill completes.
    rdy_next = in_ready && (state_next == READY);
    wr_word  = fill_we ? cnt_reg : user_word;
    wr_data  = fill_we ? fill_data : data;
    lane_we  = {NB{!rst && fill_we}} | ({NB{!rst && user_we}} & byteena);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_reg <= HOLD;
      cnt_reg   <= '0;
      rdy_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rdy_reg   <= rdy_next;
    end
  end

  assign rdy = rdy_reg;

  // One 8-bit RAM per byte lane; the read sees pre-write contents on a collision.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q_lane_reg;

    always_ff @(posedge clock) begin
      if (lane_we[gi])
        mem[wr_word] <= wr_data[8*gi +: 8];
    end

    always_ff @(posedge clock) begin
      if (rst || !in_ready)
        q_lane_reg <= '0;
      else
        q_lane_reg <= mem[user_word];
    end

    assign q[8*gi +: 8] = q_lane_reg;
  end

endmodule

// File: tb/tb_memw_init_ctrl.sv
// Bench for memw_init_ctrl: three instances (zero, constant and index fill) share stimulus;
// read expectations are queued at drive time and compared when q appears.
module tb_memw_init_ctrl;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int DL = 4;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          rst;
  logic [AW-1:0] address;
  logic [DW-1:0] data;
  logic          wren;
  logic [3:0]    byteena;
  logic          init_req;
  logic [DW-1:0] q0, q1, q2;
  logic          rdy0, rdy1, rdy2;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [3][DEPTH];

  typedef struct {
    string       tag;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;
  exp_t sb[$];

  memw_init_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL), .INIT_MODE(0), .INIT_VALUE(32'h0)) u0 (
    .clock(clock), .rst(rst), .address(address), .data(data), .wren(wren),
    .byteena(byteena), .init_req(init_req), .q(q0), .rdy(rdy0));
  memw_init_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL), .INIT_MODE(1), .INIT_VALUE(32'hDEADBEEF)) u1 (
    .clock(clock), .rst(rst), .address(address), .data(data), .wren(wren),
    .byteena(byteena), .init_req(init_req), .q(q1), .rdy(rdy1));
  memw_init_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL), .INIT_MODE(2), .INIT_VALUE(32'h0)) u2 (
    .clock(clock), .rst(rst), .address(address), .data(data), .wren(wren),
    .byteena(byteena), .init_req(init_req), .q(q2), .rdy(rdy2));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] pat(input int k, input int w);
    case (k)
      0:       return 32'h0;
      1:       return 32'hDEADBEEF;
      default: return 32'(w);
    endcase
  endfunction

  task automatic model_fill();
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < DEPTH; w++)
        mdl[k][w] = pat(k, w);
  endtask

  task automatic check_rdy(input string tag, input logic exp);
    check({tag, "/rdy0"}, {31'b0, rdy0}, {31'b0, exp});
    check({tag, "/rdy1"}, {31'b0, rdy1}, {31'b0, exp});
    check({tag, "/rdy2"}, {31'b0, rdy2}, {31'b0, exp});
  endtask

  task automatic check_q_zero(input string tag);
    check({tag, "/q0"}, q0, 32'h0);
    check({tag, "/q1"}, q1, 32'h0);
    check({tag, "/q2"}, q2, 32'h0);
  endtask

  // One READY-state cycle: q must show the word's contents from before this edge.
  task automatic access(input string tag, input logic [15:0] a, input logic [31:0] d,
                        input logic we, input logic [3:0] be);
    int   w;
    exp_t e;
    address = a;
    data    = d;
    wren    = we;
    byteena = be;
    w       = int'(a[5:2]);
    e.tag   = tag;
    e.e0    = mdl[0][w];
    e.e1    = mdl[1][w];
    e.e2    = mdl[2][w];
    sb.push_back(e);
    tick();
    wren = 1'b0;
    if (we)
      for (int k = 0; k < 3; k++)
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl[k][w][8*b +: 8] = d[8*b +: 8];
    e = sb.pop_front();
    $display("txn %s addr=%h we=%0b be=%b q=%h/%h/%h", e.tag, a, we, be, q0, q1, q2);
    check({e.tag, "/q0"}, q0, e.e0);
    check({e.tag, "/q1"}, q1, e.e1);
    check({e.tag, "/q2"}, q2, e.e2);
  endtask

  // Edges after reset release: rdy must stay low for 17 edges and be high on the 18th.
  task automatic fill_from_release(input string tag, input logic user_wr);
    if (user_wr) begin
      address = 16'h0010;
      data    = 32'h12345678;
      byteena = 4'hF;
      wren    = 1'b1;
    end
    for (int e = 1; e <= 18; e++) begin
      tick();
      if (e == 10) wren = 1'b0;
      check_rdy($sformatf("%s_e%0d", tag, e), (e == 18));
      if (e == 8) check_q_zero($sformatf("%s_qfill", tag));
    end
    wren = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    address  = '0;
    data     = '0;
    wren     = 1'b0;
    byteena  = '0;
    init_req = 1'b0;
    repeat (3) tick();
    check_rdy("reset", 1'b0);
    check_q_zero("reset");

    rst = 1'b0;
    fill_from_release("fill1", 1'b1);
    model_fill();

    for (int w = 0; w < DEPTH; w++)
      access("rd_all1", 16'(w * 4), 32'h0, 1'b0, 4'h0);
    access("rd_14", 16'h0014, 32'h0, 1'b0, 4'h0);
    check("rd_14_idx", q2, 32'h00000005);
    access("rd_54_alias", 16'h0054, 32'h0, 1'b0, 4'h0);
    check("rd_54_idx", q2, 32'h00000005);
    access("rd_10_after_fill", 16'h0010, 32'h0, 1'b0, 4'h0);
    check("rd_10_idx", q2, 32'h00000004);

    access("wr_full_08", 16'h0008, 32'h11223344, 1'b1, 4'hF);
    access("wr_be_08", 16'h0008, 32'hAABBCCDD, 1'b1, 4'b0101);
    check("same_cycle_old", q0, 32'h11223344);
    access("rd_08", 16'h0008, 32'h0, 1'b0, 4'h0);
    check("be_merge", q0, 32'h11BB33DD);
    access("wr_be0_0c", 16'h000C, 32'hFFFFFFFF, 1'b1, 4'h0);
    access("rd_0c", 16'h000C, 32'h0, 1'b0, 4'h0);
    access("wr_alias_4c", 16'h004C, 32'hCAFEF00D, 1'b1, 4'hF);
    access("rd_0f_alias", 16'h000F, 32'h0, 1'b0, 4'h0);
    check("alias_wr", q1, 32'hCAFEF00D);

    // Re-init with a colliding user write that must be dropped.
    address  = 16'h0000;
    data     = 32'h55555555;
    byteena  = 4'hF;
    wren     = 1'b1;
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    wren     = 1'b0;
    check_rdy("init_drop", 1'b0);
    model_fill();

    repeat (7) tick();
    check_rdy("fill_cnt7", 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_rdy("abort", 1'b0);
    check_q_zero("abort");
    fill_from_release("fill2", 1'b0);

    for (int w = 0; w < DEPTH; w++)
      access("rd_all2", 16'(w * 4), 32'h0, 1'b0, 4'h0);
    access("rd_00_after_init", 16'h0000, 32'h0, 1'b0, 4'h0);
    check("init_value_w0", q1, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
